wide_ser: RTL and testbench

WIDE_SER -- requirements
Module: wide_ser

---
 rtl/wide_ser.sv | 72 +++++++
 tb/tb_wide_ser.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/wide_ser.sv
// Word-to-byte serializer: accepts a 32-bit word, emits it as four bytes on a
// valid/ready stream, and can take the next word during the last byte's handshake.
module wide_ser #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [31:0] d_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  d_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] words_done
);
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] words_q, words_d;
    logic [1:0]  sel;
    logic        out_hs, last_hs, in_hs;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        words_d   = words_q;
        out_valid = (state_q == SEND);
        out_last  = out_valid && (idx_q == 2'd3);
        out_hs    = out_valid && out_ready;
        last_hs   = out_hs && (idx_q == 2'd3);
        // Reset gating keeps in_ready low while rst is held, even though IDLE.
        in_ready  = rst && ((state_q == IDLE) || last_hs);
        in_hs     = in_valid && in_ready;
        if (out_hs) begin
            if (idx_q == 2'd3) begin
                words_d = words_q + 16'd1;
                state_d = IDLE;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end
        if (in_hs) begin
            hold_d  = d_in;
            idx_d   = 2'd0;
            state_d = SEND;
        end
    end

    // d_out is always the indexed hold byte: after the last byte the index
    // stays at 3, so IDLE naturally keeps showing the last byte sent.
    assign sel        = MSB_FIRST ? ~idx_q : idx_q;
    assign d_out      = hold_q[{sel, 3'b000} +: 8];
    assign words_done = words_q;
endmodule

// File: tb/tb_wide_ser.sv
// Bench for wide_ser: both byte orders side by side, checked each cycle against
// a byte-queue model of the stream.
module tb_wide_ser;
    logic        clock;
    logic        rst;
    logic [31:0] d_in;
    logic        in_valid;
    logic        out_ready;
    logic        ir0, ir1, ov0, ov1, ol0, ol1;
    logic [7:0]  dout0, dout1;
    logic [15:0] wd0, wd1;

    wide_ser #(.MSB_FIRST(1'b0)) u0 (
        .clock(clock), .rst(rst), .d_in(d_in), .in_valid(in_valid), .in_ready(ir0),
        .d_out(dout0), .out_valid(ov0), .out_ready(out_ready), .out_last(ol0),
        .words_done(wd0));
    wide_ser #(.MSB_FIRST(1'b1)) u1 (
        .clock(clock), .rst(rst), .d_in(d_in), .in_valid(in_valid), .in_ready(ir1),
        .d_out(dout1), .out_valid(ov1), .out_ready(out_ready), .out_last(ol1),
        .words_done(wd1));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model: bytes still owed for the current word, in stream order.
    logic [7:0]  m0[$];
    logic [7:0]  m1[$];
    logic [7:0]  last0, last1;
    logic [15:0] cnt;
    logic [31:0] pend[$];
    int          pass_cnt, chk_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input logic exp_ir);
        chk("in_ready0", ir0, exp_ir);
        chk("in_ready1", ir1, exp_ir);
        chk("out_valid0", ov0, m0.size() > 0);
        chk("out_valid1", ov1, m1.size() > 0);
        chk("d_out0", dout0, (m0.size() > 0) ? m0[0] : last0);
        chk("d_out1", dout1, (m1.size() > 0) ? m1[0] : last1);
        chk("out_last0", ol0, m0.size() == 1);
        chk("out_last1", ol1, m1.size() == 1);
        chk("words0", wd0, cnt);
        chk("words1", wd1, cnt);
    endtask

    // One clock cycle: drive in the low phase, check, then advance the model.
    task automatic cyc(input logic iv, input logic [31:0] w, input logic ordy, output logic ihs);
        logic exp_ir;
        in_valid  = iv;
        d_in      = w;
        out_ready = ordy;
        #1;
        exp_ir = rst && ((m0.size() == 0) || (m0.size() == 1 && ordy));
        check_all(exp_ir);
        ihs = iv && exp_ir;
        @(posedge clock);
        if (rst) begin
            if (m0.size() > 0 && ordy) begin
                last0 = m0.pop_front();
                last1 = m1.pop_front();
                if (m0.size() == 0) cnt++;
            end
            if (ihs) begin
                for (int k = 0; k < 4; k++) begin
                    m0.push_back(w[8*k +: 8]);
                    m1.push_back(w[8*(3-k) +: 8]);
                end
            end
        end
        @(negedge clock);
    endtask

    // ordy_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
    // iv_mode: 0 offer words whenever pending, 1 random gaps.
    task automatic run(input int ordy_mode, input int iv_mode);
        int          n;
        logic        ihs, iv, ordy;
        logic [31:0] w;
        n = 0;
        while ((pend.size() > 0 || m0.size() > 0) && n < 2000) begin
            iv = (pend.size() > 0) && (iv_mode == 0 || $urandom_range(0, 1) == 1);
            w  = (pend.size() > 0) ? pend[0] : $urandom;
            case (ordy_mode)
                0:       ordy = 1'b1;
                1:       ordy = (n % 3 == 0);
                default: ordy = ($urandom_range(0, 1) == 1);
            endcase
            cyc(iv, w, ordy, ihs);
            if (ihs) void'(pend.pop_front());
            n++;
        end
        chk("drain", pend.size() + m0.size(), 0);
        cyc(1'b0, $urandom, 1'b1, ihs);
    endtask

    initial begin
        logic ihs;
        pass_cnt = 0; chk_cnt = 0;
        cnt = '0; last0 = '0; last1 = '0;
        rst = 1'b1; in_valid = 1'b0; d_in = '0; out_ready = 1'b0;
        #1 rst = 1'b0;
        #1 check_all(1'b0);
        @(negedge clock);
        cyc(1'b1, 32'hDEADBEEF, 1'b1, ihs);
        rst = 1'b1;

        pend.push_back(32'h11223344);
        run(0, 0);
        pend.push_back(32'h55AA00FF);
        run(0, 0);
        pend.push_back(32'hFFFF0000);
        pend.push_back(32'h0000FFFF);
        run(0, 0);
        pend.push_back(32'h88888888);
        run(1, 0);

        // Async reset after the 2nd byte of a word.
        cyc(1'b1, 32'hAAAAAAAA, 1'b1, ihs);
        cyc(1'b0, 32'h0, 1'b1, ihs);
        cyc(1'b0, 32'h0, 1'b1, ihs);
        rst = 1'b0;
        m0.delete(); m1.delete();
        last0 = '0; last1 = '0; cnt = '0;
        #1 check_all(1'b0);
        cyc(1'b0, 32'h0, 1'b1, ihs);
        rst = 1'b1;
        pend.push_back(32'h22222222);
        run(0, 0);

        for (int i = 0; i < 20; i++) pend.push_back($urandom);
        run(2, 1);
        for (int i = 0; i < 6; i++) pend.push_back($urandom);
        run(1, 0);

        // Stand in for 65535 completed words, then one more wraps the count.
        force u0.words_q = 16'hFFFF;
        force u1.words_q = 16'hFFFF;
        #1;
        release u0.words_q;
        release u1.words_q;
        cnt = 16'hFFFF;
        pend.push_back(32'hC0FFEE01);
        run(0, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
